irom_arbiter: RTL and testbench
===============================

IROM_ARBITER -- requirements
Module: irom_arbiter

Interface
REQ-001 Parameter BURST_MAX, default 4, SHALL set the maximum consecutive grants to one requester while the other requests; legal range 1..15.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-004 m0_req  input  1  CPU fetch port: read request.
REQ-005 m0_addr  input  32  CPU fetch byte address (`InstAddrBus).
REQ-006 m0_gnt  output  1  m0 request accepted this cycle.
REQ-007 m0_rvalid  output  1  m0_rdata valid this cycle.
REQ-008 m0_rdata  output  32  instruction word (`InstBus).
REQ-009 m1_req, m1_addr, m1_gnt, m1_rvalid, m1_rdata: debug/loader port, same widths and meanings as m0.
REQ-010 rom_ce  output  1  ROM chip enable (`ChipEnable/`ChipDisable).
REQ-011 rom_addr  output  32  ROM byte address.
REQ-012 rom_inst  input  32  ROM combinational read data.

Function
REQ-013 Handshake: a request SHALL transfer in the cycle where req=1 and gnt=1; the requester SHALL hold req/addr stable until granted.
REQ-014 At most one of m0_gnt, m1_gnt SHALL be 1 per cycle; gnt SHALL be 0 whenever the corresponding req is 0.
REQ-015 In a grant cycle, rom_ce SHALL be `ChipEnable and rom_addr SHALL equal the granted address; otherwise rom_ce=`ChipDisable and rom_addr=`ZeroWord.
REQ-016 rom_inst SHALL be registered at the grant-cycle edge; the granted port's rvalid SHALL be 1 exactly one cycle after gnt (fixed latency 1), with rdata holding the registered word.
REQ-017 rdata of a port SHALL hold its last value when rvalid=0.
REQ-018 State machine: IDLE (no grant last cycle), OWN0 (m0 granted last cycle), OWN1 (m1 granted last cycle).
REQ-019 Transitions: any state -> OWN0 on m0 grant, -> OWN1 on m1 grant, -> IDLE when no grant.
REQ-020 A 4-bit burst counter SHALL count consecutive grants to the current owner while the other port requests; it SHALL reset to 0 on owner change or when the other port is not requesting.
REQ-021 Simultaneous requests: the current owner keeps the grant until the counter reaches BURST_MAX, then the other port SHALL be granted next cycle.
REQ-022 Simultaneous requests from IDLE: tie-break per REQ-029.
REQ-023 A single requester SHALL be granted every cycle (back-to-back, full throughput).
REQ-024 Addresses are passed through unmodified; word selection is the ROM's responsibility.

Reset
REQ-025 While rst=0: state=IDLE, burst counter=0, last-winner=m1, m0_gnt=m1_gnt=0, m0_rvalid=m1_rvalid=0, m0_rdata=m1_rdata=`ZeroWord, rom_ce=`ChipDisable, rom_addr=`ZeroWord.
REQ-026 A grant in flight when rst asserts SHALL be dropped; no rvalid SHALL follow after reset release.
REQ-027 First grant SHALL be possible in the first cycle after rst deasserts.

Configuration
REQ-028 Macro IROM_ARB_RR_EN selects the IDLE tie-break policy.
REQ-029 Defined: IDLE tie-break is round-robin (port not granted most recently wins; reset last-winner=m1, so m0 wins first). Undefined: IDLE tie-break is fixed, m0 wins; burst limit (REQ-021) applies in both builds.

Structure
REQ-030 Shared package irom_arb_pkg SHALL hold the state enum (IDLE/OWN0/OWN1) and the port-id type; bus widths and `ChipEnable/`ZeroWord come from defines.sv.
REQ-031 One sub-module, irom_arb_resp_reg (per-port rvalid/rdata register), SHALL be instantiated twice; no other hierarchy.

Verification
REQ-032 Reset: hold rst=0 with m0_req=1 -> all outputs at REQ-025 values; release -> m0_gnt=1 same cycle, m0_rvalid=1 next cycle.
REQ-033 Single port: m0 requests addr 0x0,0x4,0x8 back-to-back, ROM words 0x34011100.. -> gnt on 3 consecutive cycles, rvalid on the next 3 with matching data.
REQ-034 Contention (BURST_MAX=4): m0 in OWN0, m1 and m0 both request continuously -> m0 granted 4 consecutive cycles, then m1 4, alternating; no cycle with both gnt.
REQ-035 IDLE tie: both request from IDLE after reset -> m0 granted; repeat after an m0-only grant -> m1 granted with IROM_ARB_RR_EN, m0 granted without.
REQ-036 Reset mid-operation: assert rst in the cycle after m1_gnt -> m1_rvalid=0, no late rvalid after release.
REQ-037 Idle: no requests for 10 cycles -> rom_ce=`ChipDisable, rom_addr=0, rdata unchanged throughout.

Source files
------------

// File: rtl/irom_arb_pkg.sv
// Types shared by the instruction-ROM arbiter: ownership state and port identifier.
package irom_arb_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StOwn0 = 2'd1,
        StOwn1 = 2'd2
    } arb_state_e;

    typedef enum logic {
        PortM0 = 1'b0,
        PortM1 = 1'b1
    } port_id_e;

endpackage

// File: rtl/defines.sv
// Shared bus widths and ROM control encodings for the instruction-fetch path.
`ifndef IROM_DEFINES_SV
`define IROM_DEFINES_SV
`define InstAddrBus 31:0
`define InstBus     31:0
`define ChipEnable  1'b1
`define ChipDisable 1'b0
`define ZeroWord    32'h0
`endif

// File: rtl/irom_arb_resp_reg.sv
// Per-port response register: captures the ROM word at the grant edge, valid one cycle later.
`include "defines.sv"

module irom_arb_resp_reg (
    input  logic            clk,
    input  logic            rst,
    input  logic            gnt,
    input  logic [`InstBus] rom_inst,
    output logic            rvalid,
    output logic [`InstBus] rdata
);

    logic            rvalid_q;
    logic [`InstBus] rdata_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rvalid_q <= 1'b0;
            rdata_q  <= `ZeroWord;
        end else begin
            rvalid_q <= gnt;
            if (gnt) begin
                rdata_q <= rom_inst;
            end
        end
    end

    assign rvalid = rvalid_q;
    assign rdata  = rdata_q;

endmodule

// File: rtl/irom_arbiter.sv
// Two-port instruction-ROM arbiter with burst-limited ownership and 1-cycle read latency.
// IROM_ARB_RR_EN: round-robin tie-break from idle (default: m0 wins ties from idle).
`include "defines.sv"

module irom_arbiter
    import irom_arb_pkg::*;
#(
    parameter int unsigned BURST_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                m0_req,
    input  logic [`InstAddrBus] m0_addr,
    output logic                m0_gnt,
    output logic                m0_rvalid,
    output logic [`InstBus]     m0_rdata,
    input  logic                m1_req,
    input  logic [`InstAddrBus] m1_addr,
    output logic                m1_gnt,
    output logic                m1_rvalid,
    output logic [`InstBus]     m1_rdata,
    output logic                rom_ce,
    output logic [`InstAddrBus] rom_addr,
    input  logic [`InstBus]     rom_inst
);

    localparam logic [3:0] BurstLimit = 4'(BURST_MAX);

    arb_state_e state_q, state_d;
    logic [3:0] burst_q, burst_d;
    port_id_e   last_q, last_d;

    logic     win_valid;
    port_id_e win;
    logic     other_req;
    logic     same_owner;

    // Winner selection: contention resolved by current owner and burst count.
    always_comb begin
        win_valid = 1'b0;
        win       = PortM0;
        if (m0_req && m1_req) begin
            win_valid = 1'b1;
            case (state_q)
                StOwn0:  win = (burst_q >= BurstLimit) ? PortM1 : PortM0;
                StOwn1:  win = (burst_q >= BurstLimit) ? PortM0 : PortM1;
                default: begin
`ifdef IROM_ARB_RR_EN
                    win = (last_q == PortM0) ? PortM1 : PortM0;
`else
                    win = PortM0;
`endif
                end
            endcase
        end else if (m0_req) begin
            win_valid = 1'b1;
            win       = PortM0;
        end else if (m1_req) begin
            win_valid = 1'b1;
            win       = PortM1;
        end
    end

    // Grants are suppressed while reset is held so nothing is captured in flight.
    assign m0_gnt = rst && win_valid && (win == PortM0);
    assign m1_gnt = rst && win_valid && (win == PortM1);

    always_comb begin
        rom_ce   = `ChipDisable;
        rom_addr = `ZeroWord;
        if (m0_gnt) begin
            rom_ce   = `ChipEnable;
            rom_addr = m0_addr;
        end else if (m1_gnt) begin
            rom_ce   = `ChipEnable;
            rom_addr = m1_addr;
        end
    end

    always_comb begin
        other_req  = (win == PortM0) ? m1_req : m0_req;
        same_owner = ((state_q == StOwn0) && (win == PortM0)) ||
                     ((state_q == StOwn1) && (win == PortM1));
        state_d    = StIdle;
        burst_d    = 4'd0;
        last_d     = last_q;
        if (win_valid) begin
            state_d = (win == PortM0) ? StOwn0 : StOwn1;
            last_d  = win;
            if (other_req) begin
                burst_d = same_owner ? burst_q + 4'd1 : 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            burst_q <= 4'd0;
            last_q  <= PortM1;
        end else begin
            state_q <= state_d;
            burst_q <= burst_d;
            last_q  <= last_d;
        end
    end

    irom_arb_resp_reg u_resp_m0 (
        .clk      (clk),
        .rst      (rst),
        .gnt      (m0_gnt),
        .rom_inst (rom_inst),
        .rvalid   (m0_rvalid),
        .rdata    (m0_rdata)
    );

    irom_arb_resp_reg u_resp_m1 (
        .clk      (clk),
        .rst      (rst),
        .gnt      (m1_gnt),
        .rom_inst (rom_inst),
        .rvalid   (m1_rvalid),
        .rdata    (m1_rdata)
    );

endmodule

// File: tb/tb_irom_arbiter.sv
// Scoreboard bench for irom_arbiter: directed phases plus randomized contention.
module tb_irom_arbiter;

    localparam int unsigned BURST_MAX = 4;
`ifdef IROM_ARB_RR_EN
    localparam bit RrEn = 1'b1;
`else
    localparam bit RrEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        m0_req = 1'b0, m1_req = 1'b0;
    logic [31:0] m0_addr = 32'h0, m1_addr = 32'h0;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, rom_ce;
    logic [31:0] m0_rdata, m1_rdata, rom_addr, rom_inst;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return 32'h34011100 + a;
    endfunction

    assign rom_inst = rom_word(rom_addr);

    irom_arbiter #(.BURST_MAX(BURST_MAX)) dut (
        .clk       (clk),
        .rst       (rst),
        .m0_req    (m0_req),
        .m0_addr   (m0_addr),
        .m0_gnt    (m0_gnt),
        .m0_rvalid (m0_rvalid),
        .m0_rdata  (m0_rdata),
        .m1_req    (m1_req),
        .m1_addr   (m1_addr),
        .m1_gnt    (m1_gnt),
        .m1_rvalid (m1_rvalid),
        .m1_rdata  (m1_rdata),
        .rom_ce    (rom_ce),
        .rom_addr  (rom_addr),
        .rom_inst  (rom_inst)
    );

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] hold0 = 32'h0, hold1 = 32'h0;
    int          checks = 0, failures = 0;

    // Reference model: who owns the ROM, how long they have held it under contention,
    // and who won most recently.
    int owner = -1;
    int run = 0;
    int last_win = 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic int model_pick(input bit r0, input bit r1);
        if (r0 && r1) begin
            if (owner < 0) return RrEn ? (1 - last_win) : 0;
            return (run >= int'(BURST_MAX)) ? (1 - owner) : owner;
        end
        if (r0) return 0;
        if (r1) return 1;
        return -1;
    endfunction

    task automatic model_update(input int w, input bit r0, input bit r1);
        bit other;
        other = (w == 0) ? r1 : r0;
        if (w >= 0 && other) run = (w == owner) ? run + 1 : 1;
        else run = 0;
        owner = w;
        if (w >= 0) last_win = w;
    endtask

    task automatic model_reset();
        owner = -1;
        run = 0;
        last_win = 1;
        q0.delete();
        q1.delete();
        hold0 = 32'h0;
        hold1 = 32'h0;
    endtask

    // One bus cycle: drive at negedge, check combinational outputs, queue expected reads.
    task automatic step(input bit rv, input bit r0, input logic [31:0] a0,
                        input bit r1, input logic [31:0] a1, output int w);
        logic [31:0] ea;
        @(negedge clk);
        rst = rv;
        m0_req = r0;
        m0_addr = a0;
        m1_req = r1;
        m1_addr = a1;
        #1;
        if (!rv) begin
            model_reset();
            w = -1;
            chk("rst_m0_rvalid", 32'(m0_rvalid), 32'h0);
            chk("rst_m1_rvalid", 32'(m1_rvalid), 32'h0);
            chk("rst_m0_rdata", m0_rdata, 32'h0);
            chk("rst_m1_rdata", m1_rdata, 32'h0);
        end else begin
            w = model_pick(r0, r1);
        end
        ea = (w == 0) ? a0 : (w == 1) ? a1 : 32'h0;
        chk("m0_gnt", 32'(m0_gnt), 32'(w == 0));
        chk("m1_gnt", 32'(m1_gnt), 32'(w == 1));
        chk("rom_ce", 32'(rom_ce), 32'(w >= 0));
        chk("rom_addr", rom_addr, ea);
        if (w == 0) q0.push_back('{cyc + 1, rom_word(a0)});
        if (w == 1) q1.push_back('{cyc + 1, rom_word(a1)});
        if (rv) model_update(w, r0, r1);
    endtask

    task automatic mon(input int p, input logic v, input logic [31:0] d);
        exp_t e;
        bit   have;
        have = (p == 0) ? (q0.size() > 0) : (q1.size() > 0);
        if (have) e = (p == 0) ? q0[0] : q1[0];
        if (have && e.cyc < cyc) begin
            chk(p == 0 ? "m0_rvalid_missing" : "m1_rvalid_missing", 32'(v), 32'h1);
            if (p == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            have = 1'b0;
        end
        if (v) begin
            if (!have || e.cyc != cyc) begin
                chk(p == 0 ? "m0_rvalid_unexpected" : "m1_rvalid_unexpected", 32'(v), 32'h0);
            end else begin
                chk(p == 0 ? "m0_rdata" : "m1_rdata", d, e.data);
                if (p == 0) begin
                    void'(q0.pop_front());
                    hold0 = e.data;
                end else begin
                    void'(q1.pop_front());
                    hold1 = e.data;
                end
            end
        end else begin
            chk(p == 0 ? "m0_rdata_hold" : "m1_rdata_hold", d, (p == 0) ? hold0 : hold1);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #2;
            mon(0, m0_rvalid, m0_rdata);
            mon(1, m1_rvalid, m1_rdata);
        end
    end

    initial begin
        int          w;
        bit          p0, p1;
        logic [31:0] a0, a1;

        // Reset held with m0 requesting, then release: grant in the first cycle.
        repeat (3) step(1'b0, 1'b1, 32'h0, 1'b0, 32'h0, w);
        step(1'b1, 1'b1, 32'h0, 1'b0, 32'h0, w);
        // Single requester back-to-back.
        step(1'b1, 1'b1, 32'h0, 1'b0, 32'h0, w);
        step(1'b1, 1'b1, 32'h4, 1'b0, 32'h0, w);
        step(1'b1, 1'b1, 32'h8, 1'b0, 32'h0, w);
        // Contention starting with m0 already owning.
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 32'h100 + 32'(i * 4), 1'b1, 32'h200 + 32'(i * 4), w);
        end
        // Idle tie right after reset, then after an m0-only grant.
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, w);
        step(1'b1, 1'b1, 32'h10, 1'b1, 32'h20, w);
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, w);
        step(1'b1, 1'b1, 32'h14, 1'b0, 32'h0, w);
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, w);
        step(1'b1, 1'b1, 32'h18, 1'b1, 32'h28, w);
        // m1 granted, reset asserted the following cycle.
        step(1'b1, 1'b0, 32'h0, 1'b1, 32'h40, w);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, w);
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, w);
        // Reset asserted inside a grant cycle: the read must be dropped.
        step(1'b1, 1'b0, 32'h0, 1'b1, 32'h44, w);
        #2;
        rst = 1'b0;
        model_reset();
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, w);
        step(1'b1, 1'b1, 32'h48, 1'b0, 32'h0, w);
        // Ten idle cycles.
        repeat (10) step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, w);
        // Randomized traffic; requesters hold req/addr until granted.
        p0 = 1'b0;
        p1 = 1'b0;
        a0 = 32'h0;
        a1 = 32'h0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 249) == 0) begin
                step(1'b0, p0, a0, p1, a1, w);
                p0 = 1'b0;
                p1 = 1'b0;
                continue;
            end
            if (!p0 && $urandom_range(0, 99) < 65) begin
                p0 = 1'b1;
                a0 = $urandom & 32'hFFFF_FFFC;
            end
            if (!p1 && $urandom_range(0, 99) < 55) begin
                p1 = 1'b1;
                a1 = $urandom & 32'hFFFF_FFFC;
            end
            step(1'b1, p0, a0, p1, a1, w);
            if (w == 0) p0 = 1'b0;
            if (w == 1) p1 = 1'b0;
        end
        repeat (3) step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, w);
        chk("m0_queue_drained", 32'(q0.size()), 32'h0);
        chk("m1_queue_drained", 32'(q1.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
